keyprt_cmd_sequencer: RTL and testbench



---
 rtl/keyprt_cmd_sequencer.sv | 78 +++++++
 tb/tb_keyprt_cmd_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/keyprt_cmd_sequencer.sv
// keyprt_cmd_sequencer: turns key/pop requests into timed command-port waveforms and captures pop results
module keyprt_cmd_sequencer #(
  parameter int KEY_HOLD = 50000,
  parameter int KEY_GAP  = 50000,
  parameter int POP_HOLD = 10000,
  parameter int POP_GAP  = 10000,
  parameter int CNT_W    = 17
) (
  input  logic        CLK,
  input  logic        RES_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_KIND,
  input  logic [7:0]  REQ_CODE,
  output logic [31:0] PORT_KEYPRT_CMD,
  input  logic [31:0] PORT_KEYPRT_RES,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_DATA,
  output logic        BUSY
);
  typedef enum logic [2:0] {IDLE, KEY_ON, KEY_OFF, POP_ON, POP_OFF} state_t;
  localparam logic [CNT_W-1:0] KH = CNT_W'(KEY_HOLD - 1);
  localparam logic [CNT_W-1:0] KG = CNT_W'(KEY_GAP - 1);
  localparam logic [CNT_W-1:0] PH = CNT_W'(POP_HOLD - 1);
  localparam logic [CNT_W-1:0] PG = CNT_W'(POP_GAP - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0] cmd_n, rsp_data_n;
  logic rsp_valid_n, accept, done;
  assign REQ_READY = RES_N && state == IDLE && (!REQ_KIND || !RSP_VALID);
  assign accept = REQ_VALID && REQ_READY;
  assign done = cnt == '0;
  assign BUSY = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = done ? cnt : cnt - CNT_W'(1);
    cmd_n = PORT_KEYPRT_CMD;
    rsp_valid_n = RSP_VALID && !RSP_READY;
    rsp_data_n = RSP_DATA;
    case (state)
      IDLE: if (accept) begin
        state_n = REQ_KIND ? POP_ON : KEY_ON;
        cnt_n = REQ_KIND ? PH : KH;
        cmd_n = REQ_KIND ? 32'h0000_8000 : {24'h0, REQ_CODE};
      end
      KEY_ON: if (done) begin
        state_n = KEY_OFF;
        cnt_n = KG;
        cmd_n = '0;
      end
      POP_ON: if (done) begin
        state_n = POP_OFF;
        cnt_n = PG;
        cmd_n = '0;
        rsp_valid_n = 1'b1;
        rsp_data_n = PORT_KEYPRT_RES;
      end
      KEY_OFF, POP_OFF: if (done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RES_N) begin
      state <= IDLE;
      cnt <= '0;
      PORT_KEYPRT_CMD <= '0;
      RSP_VALID <= 1'b0;
      RSP_DATA <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      PORT_KEYPRT_CMD <= cmd_n;
      RSP_VALID <= rsp_valid_n;
      RSP_DATA <= rsp_data_n;
    end
  end
endmodule

// File: tb/tb_keyprt_cmd_sequencer.sv
// tb_keyprt_cmd_sequencer: directed checks of key/pop timing, response handshake, back-to-back and reset
module tb_keyprt_cmd_sequencer;
  logic tb_clk = 1'b0;
  logic res_n = 1'b0, req_valid = 1'b0, req_kind = 1'b0, rsp_ready = 1'b0;
  logic req_ready, rsp_valid, busy;
  logic [7:0] req_code = 8'h00;
  logic [31:0] res = 32'hA5A5_1234;
  logic [31:0] cmd, rsp_data;
  logic [7:0] codes [7] = '{8'h9B, 8'h97, 8'h8E, 8'h93, 8'h9A, 8'h8E, 8'h8C};
  int n_chk = 0, n_pass = 0;
  always #5 tb_clk = ~tb_clk;
  keyprt_cmd_sequencer #(.KEY_HOLD(4), .KEY_GAP(3), .POP_HOLD(2), .POP_GAP(2), .CNT_W(17)) dut (
    .CLK(tb_clk), .RES_N(res_n), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_KIND(req_kind), .REQ_CODE(req_code), .PORT_KEYPRT_CMD(cmd),
    .PORT_KEYPRT_RES(res), .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
    .RSP_DATA(rsp_data), .BUSY(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic step;
    @(posedge tb_clk);
    @(negedge tb_clk);
  endtask
  task automatic key_trace(input string tag, input logic [7:0] code);
    for (int i = 1; i <= 7; i++) begin
      chk($sformatf("%s cmd t+%0d", tag, i), cmd, i <= 4 ? {24'h0, code} : 32'h0);
      chk($sformatf("%s busy t+%0d", tag, i), {31'h0, busy}, 32'h1);
      step;
    end
    chk({tag, " busy end"}, {31'h0, busy}, 32'h0);
  endtask
  task automatic accept_key(input string tag, input logic [7:0] code);
    req_valid = 1'b1;
    req_kind = 1'b0;
    req_code = code;
    #1;
    chk({tag, " ready"}, {31'h0, req_ready}, 32'h1);
    step;
    req_valid = 1'b0;
    req_code = 8'hFF;
  endtask
  initial begin
    @(negedge tb_clk);
    step;
    step;
    chk("rst cmd", cmd, 32'h0);
    chk("rst busy", {31'h0, busy}, 32'h0);
    chk("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst rsp_data", rsp_data, 32'h0);
    req_valid = 1'b1;
    #1;
    chk("rst ready", {31'h0, req_ready}, 32'h0);
    req_valid = 1'b0;
    res_n = 1'b1;
    step;
    accept_key("key9b", 8'h9B);
    key_trace("key9b", 8'h9B);
    chk("key9b ready again", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1;
    req_kind = 1'b1;
    #1;
    chk("pop ready", {31'h0, req_ready}, 32'h1);
    step;
    req_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("pop cmd t+%0d", i), cmd, i <= 2 ? 32'h0000_8000 : 32'h0);
      chk($sformatf("pop rsp_valid t+%0d", i), {31'h0, rsp_valid}, i >= 3 ? 32'h1 : 32'h0);
      if (i == 3) chk("pop rsp_data", rsp_data, 32'hA5A5_1234);
      step;
    end
    chk("pop busy end", {31'h0, busy}, 32'h0);
    res = 32'h0BAD_F00D;
    req_valid = 1'b1;
    req_kind = 1'b1;
    #1;
    chk("pop2 blocked", {31'h0, req_ready}, 32'h0);
    step;
    step;
    chk("pop2 still blocked", {31'h0, req_ready}, 32'h0);
    chk("pop2 not busy", {31'h0, busy}, 32'h0);
    rsp_ready = 1'b1;
    #1;
    chk("pop2 blocked during consume", {31'h0, req_ready}, 32'h0);
    step;
    rsp_ready = 1'b0;
    chk("consume rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("consume rsp_data held", rsp_data, 32'hA5A5_1234);
    #1;
    chk("pop2 ready", {31'h0, req_ready}, 32'h1);
    step;
    req_valid = 1'b0;
    chk("pop2 cmd", cmd, 32'h0000_8000);
    chk("pop2 busy", {31'h0, busy}, 32'h1);
    repeat (4) step;
    chk("pop2 rsp_data", rsp_data, 32'h0BAD_F00D);
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    chk("pop2 consumed", {31'h0, rsp_valid}, 32'h0);
    req_valid = 1'b1;
    req_kind = 1'b0;
    for (int k = 0; k < 7; k++) begin
      req_code = codes[k];
      #1;
      chk($sformatf("b2b ready %0d", k), {31'h0, req_ready}, 32'h1);
      step;
      req_code = 8'hFF;
      req_kind = 1'b1;
      for (int i = 1; i <= 7; i++) begin
        chk($sformatf("b2b %0d cmd t+%0d", k, i), cmd, i <= 4 ? {24'h0, codes[k]} : 32'h0);
        step;
      end
      req_kind = 1'b0;
    end
    req_valid = 1'b0;
    req_valid = 1'b1;
    req_kind = 1'b1;
    step;
    req_valid = 1'b0;
    repeat (4) step;
    chk("pre-rst rsp_valid", {31'h0, rsp_valid}, 32'h1);
    accept_key("key55", 8'h55);
    step;
    chk("key55 cmd 2nd", cmd, 32'h0000_0055);
    res_n = 1'b0;
    req_valid = 1'b1;
    req_code = 8'h11;
    req_kind = 1'b0;
    #1;
    chk("midrst ready", {31'h0, req_ready}, 32'h0);
    step;
    chk("midrst cmd", cmd, 32'h0);
    chk("midrst busy", {31'h0, busy}, 32'h0);
    chk("midrst rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("midrst rsp_data", rsp_data, 32'h0);
    res_n = 1'b1;
    #1;
    chk("postrst ready", {31'h0, req_ready}, 32'h1);
    step;
    req_valid = 1'b0;
    key_trace("key11", 8'h11);
    accept_key("key00", 8'h00);
    key_trace("key00", 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
